// File: rtl/dsp_run_ctrl.sv
// Program-load and run sequencer for the dsp core: streams words into imem/dmem,
// pulses the core reset, then runs until halt or a cycle budget, reporting status.
module dsp_run_ctrl #(
   parameter int unsigned WORD_W     = 16,
   parameter int unsigned IMEM_DEPTH = 256,
   parameter int unsigned DMEM_DEPTH = 256,
   parameter int unsigned RST_CYCLES = 4,
   parameter logic [31:0] TIMEOUT    = 32'd4096,
   localparam int unsigned IA_W      = $clog2(IMEM_DEPTH),
   localparam int unsigned DA_W      = $clog2(DMEM_DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_load_valid,
   output logic              o_load_ready,
   input  logic              i_load_sel,
   input  logic [WORD_W-1:0] i_load_data,
   input  logic              i_start,
   input  logic              i_clear,
   output logic              o_imem_we,
   output logic [IA_W-1:0]   o_imem_addr,
   output logic [WORD_W-1:0] o_imem_wdata,
   output logic              o_dmem_we,
   output logic [DA_W-1:0]   o_dmem_addr,
   output logic [WORD_W-1:0] o_dmem_wdata,
   output logic              o_cpu_rst,
   input  logic              i_cpu_halt,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_timeout,
   output logic              o_load_err,
   output logic [31:0]       o_cycle_count
);

   localparam int unsigned RC_W = $clog2(RST_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_RSTP, S_RUN, S_DONE} state_t;

   state_t              r_state, w_next;
   logic [IA_W:0]       r_icnt;
   logic [DA_W:0]       r_dcnt;
   logic [RC_W-1:0]     r_rst_cnt;
   logic [31:0]         r_cycle_count;
   logic                r_timeout, r_load_err;
   logic                r_imem_we, r_dmem_we;
   logic [IA_W-1:0]     r_imem_addr;
   logic [DA_W-1:0]     r_dmem_addr;
   logic [WORD_W-1:0]   r_imem_wdata, r_dmem_wdata;

   logic w_load_fire, w_i_full, w_d_full, w_go, w_clr, w_rst_last, w_cc_max;

   assign w_load_fire = i_load_valid && (r_state == S_IDLE);
   // Counters are one bit wider than the address so "full" (== DEPTH) is representable.
   assign w_i_full    = (r_icnt == (IA_W + 1)'(IMEM_DEPTH));
   assign w_d_full    = (r_dcnt == (DA_W + 1)'(DMEM_DEPTH));
   assign w_go        = i_start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_clr       = i_clear && !i_start && (r_state == S_DONE);
   assign w_rst_last  = (r_rst_cnt == RC_W'(RST_CYCLES - 1));
   assign w_cc_max    = (r_cycle_count == TIMEOUT);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      o_load_ready = 1'b0;
      o_cpu_rst    = 1'b1;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_load_ready = 1'b1;
            if (i_start) w_next = S_RSTP;
         end
         S_RSTP: begin
            o_busy = 1'b1;
            if (w_rst_last) w_next = S_RUN;
         end
         S_RUN: begin
            o_busy    = 1'b1;
            o_cpu_rst = 1'b0;
            if (i_cpu_halt || w_cc_max) w_next = S_DONE;
         end
         S_DONE: begin
            o_done = 1'b1;
            if (i_start)      w_next = S_RSTP;
            else if (i_clear) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_icnt        <= '0;
         r_dcnt        <= '0;
         r_rst_cnt     <= '0;
         r_cycle_count <= '0;
         r_timeout     <= 1'b0;
         r_load_err    <= 1'b0;
         r_imem_we     <= 1'b0;
         r_dmem_we     <= 1'b0;
         r_imem_addr   <= '0;
         r_dmem_addr   <= '0;
         r_imem_wdata  <= '0;
         r_dmem_wdata  <= '0;
      end else begin
         r_imem_we <= 1'b0;
         r_dmem_we <= 1'b0;
         if (w_load_fire) begin
            if (!i_load_sel) begin
               if (w_i_full) r_load_err <= 1'b1;
               else begin
                  r_imem_we    <= 1'b1;
                  r_imem_addr  <= r_icnt[IA_W-1:0];
                  r_imem_wdata <= i_load_data;
                  r_icnt       <= r_icnt + (IA_W + 1)'(1);
               end
            end else begin
               if (w_d_full) r_load_err <= 1'b1;
               else begin
                  r_dmem_we    <= 1'b1;
                  r_dmem_addr  <= r_dcnt[DA_W-1:0];
                  r_dmem_wdata <= i_load_data;
                  r_dcnt       <= r_dcnt + (DA_W + 1)'(1);
               end
            end
         end
         if (w_clr) begin
            r_icnt     <= '0;
            r_dcnt     <= '0;
            r_load_err <= 1'b0;
         end
         if (w_go) begin
            r_rst_cnt     <= '0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
         end
         if (r_state == S_RSTP && !w_rst_last) r_rst_cnt <= r_rst_cnt + RC_W'(1);
         // Halt takes priority over the budget check; the halting cycle is not counted.
         if (r_state == S_RUN && !i_cpu_halt) begin
            if (w_cc_max) r_timeout     <= 1'b1;
            else          r_cycle_count <= r_cycle_count + 32'd1;
         end
      end
   end

   assign o_imem_we     = r_imem_we;
   assign o_imem_addr   = r_imem_addr;
   assign o_imem_wdata  = r_imem_wdata;
   assign o_dmem_we     = r_dmem_we;
   assign o_dmem_addr   = r_dmem_addr;
   assign o_dmem_wdata  = r_dmem_wdata;
   assign o_timeout     = r_timeout;
   assign o_load_err    = r_load_err;
   assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_dsp_run_ctrl.sv
// Randomized bench for dsp_run_ctrl against a transaction-level model of the
// load counters, run length and final status.
module tb_dsp_run_ctrl;

   localparam int unsigned WW = 16;
   localparam int unsigned ID = 4;
   localparam int unsigned DD = 8;
   localparam int unsigned RC = 4;
   localparam int unsigned TO = 16;

   logic          clk = 1'b0, reset = 1'b1;
   logic          load_valid = 1'b0, load_sel = 1'b0, start = 1'b0, clear = 1'b0, cpu_halt = 1'b0;
   logic [WW-1:0] load_data = '0;
   logic          load_ready, imem_we, dmem_we, cpu_rst, busy, done, timeout, load_err;
   logic [1:0]    imem_addr;
   logic [2:0]    dmem_addr;
   logic [WW-1:0] imem_wdata, dmem_wdata;
   logic [31:0]   cycle_count;

   dsp_run_ctrl #(.WORD_W(WW), .IMEM_DEPTH(ID), .DMEM_DEPTH(DD), .RST_CYCLES(RC),
                  .TIMEOUT(32'(TO))) dut (
      .i_clk(clk), .i_reset(reset), .i_load_valid(load_valid), .o_load_ready(load_ready),
      .i_load_sel(load_sel), .i_load_data(load_data), .i_start(start), .i_clear(clear),
      .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata),
      .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
      .o_cpu_rst(cpu_rst), .i_cpu_halt(cpu_halt), .o_busy(busy), .o_done(done),
      .o_timeout(timeout), .o_load_err(load_err), .o_cycle_count(cycle_count));

   always #5 clk = ~clk;

   // Memories as the core would see them, built from the write ports.
   logic [WW-1:0] tb_imem [ID];
   logic [WW-1:0] tb_dmem [DD];
   always @(posedge clk) begin
      if (imem_we) tb_imem[imem_addr] <= imem_wdata;
      if (dmem_we) tb_dmem[dmem_addr] <= dmem_wdata;
   end

   // Reference model
   int            n_chk = 0, n_fail = 0;
   int            m_icnt, m_dcnt;
   bit            m_err;
   bit            m_idle;
   logic [WW-1:0] m_imem [ID];
   logic [WW-1:0] m_dmem [DD];
   bit            m_iv [ID];
   bit            m_dv [DD];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_icnt = 0; m_dcnt = 0; m_err = 0; m_idle = 1;
   endtask

   // Called in the cycle after a load handshake edge.
   task automatic eval_load(input bit sel, input logic [WW-1:0] d);
      bit wr;
      int a;
      wr = 0; a = 0;
      if (!sel && m_icnt < ID) begin
         wr = 1; a = m_icnt; m_imem[a] = d; m_iv[a] = 1; m_icnt++;
      end else if (sel && m_dcnt < DD) begin
         wr = 1; a = m_dcnt; m_dmem[a] = d; m_dv[a] = 1; m_dcnt++;
      end else m_err = 1;
      chk("imem_we", 32'(imem_we), 32'(wr && !sel));
      chk("dmem_we", 32'(dmem_we), 32'(wr && sel));
      if (wr && !sel) begin
         chk("imem_addr", 32'(imem_addr), 32'(a));
         chk("imem_wdata", 32'(imem_wdata), 32'(d));
      end
      if (wr && sel) begin
         chk("dmem_addr", 32'(dmem_addr), 32'(a));
         chk("dmem_wdata", 32'(dmem_wdata), 32'(d));
      end
      chk("load_err", 32'(load_err), 32'(m_err));
   endtask

   task automatic push(input bit sel, input logic [WW-1:0] d);
      chk("load_ready", 32'(load_ready), 32'd1);
      load_valid = 1; load_sel = sel; load_data = d;
      step();
      eval_load(sel, d);
   endtask

   task automatic end_burst();
      load_valid = 0;
      step();
      chk("we_idle", {30'd0, imem_we, dmem_we}, 32'd0);
   endtask

   // Start a run (optionally with clear or a final load word) and halt in RUN cycle h.
   task automatic run(input int h, input bit with_clear, input bit with_load, input bit noise);
      int rstc, runc, guard, exp_cc;
      bit lsel;
      logic [WW-1:0] ld;
      lsel = 1'($urandom); ld = WW'($urandom);
      start = 1; clear = with_clear;
      if (with_load) begin load_valid = 1; load_sel = lsel; load_data = ld; end
      step();
      start = 0; clear = 0; load_valid = 0;
      if (with_load) eval_load(lsel, ld);
      m_idle = 0;
      chk("go_busy", 32'(busy), 32'd1);
      chk("go_cc", cycle_count, 32'd0);
      chk("go_to", 32'(timeout), 32'd0);
      chk("go_ready", 32'(load_ready), 32'd0);
      rstc = 0; guard = 0;
      while (busy && cpu_rst && guard < 100) begin rstc++; guard++; step(); end
      chk("rst_len", 32'(rstc), 32'(RC));
      runc = 0;
      while (busy && !cpu_rst && guard < 300) begin
         chk("run_cc", cycle_count, 32'(runc));
         chk("run_we", {30'd0, imem_we, dmem_we}, 32'd0);
         cpu_halt = (runc == h);
         if (noise) begin
            load_valid = 1'($urandom); start = 1'($urandom); clear = 1'($urandom);
            load_sel = 1'($urandom);
         end
         runc++; guard++;
         step();
      end
      cpu_halt = 0; load_valid = 0; start = 0; clear = 0;
      exp_cc = (h <= int'(TO)) ? h : int'(TO);
      chk("run_len", 32'(runc), 32'(exp_cc + 1));
      chk("end_cc", cycle_count, 32'(exp_cc));
      chk("end_to", 32'(timeout), 32'(h > int'(TO)));
      chk("end_done", 32'(done), 32'd1);
      chk("end_cpurst", 32'(cpu_rst), 32'd1);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_err", 32'(load_err), 32'(m_err));
      step();
      chk("hold_cc", cycle_count, 32'(exp_cc));
      chk("hold_done", 32'(done), 32'd1);
   endtask

   task automatic do_clear();
      clear = 1;
      step();
      clear = 0;
      m_icnt = 0; m_dcnt = 0; m_err = 0; m_idle = 1;
      chk("clr_ready", 32'(load_ready), 32'd1);
      chk("clr_done", 32'(done), 32'd0);
      chk("clr_err", 32'(load_err), 32'd0);
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_ready"}, 32'(load_ready), 32'd1);
      chk({pfx, "_cpurst"}, 32'(cpu_rst), 32'd1);
      chk({pfx, "_we"}, {30'd0, imem_we, dmem_we}, 32'd0);
      chk({pfx, "_addr"}, {27'd0, imem_addr, dmem_addr}, 32'd0);
      chk({pfx, "_wdata"}, {imem_wdata, dmem_wdata}, 32'd0);
      chk({pfx, "_flags"}, {28'd0, busy, done, timeout, load_err}, 32'd0);
      chk({pfx, "_cc"}, cycle_count, 32'd0);
   endtask

   initial begin
      int guard;
      logic [WW-1:0] basic_i [3];
      logic [WW-1:0] basic_d [2];
      basic_i[0] = 16'h1111; basic_i[1] = 16'h2222; basic_i[2] = 16'h3333;
      basic_d[0] = 16'hA5A5; basic_d[1] = 16'h5A5A;
      model_reset();
      #12;
      chk_reset_vals("rst");
      @(posedge clk); #1; reset = 0;

      // Basic load and run, then rerun from DONE with ignored-input noise
      foreach (basic_i[i]) push(1'b0, basic_i[i]);
      foreach (basic_d[i]) push(1'b1, basic_d[i]);
      end_burst();
      run(10, 0, 0, 0);
      run(int'($urandom_range(0, TO - 1)), 0, 0, 1);

      // Timeout, halt exactly at the budget, start+clear together in DONE
      run(1000, 0, 0, 0);
      run(int'(TO), 0, 0, 1);
      run(3, 1, 0, 0);

      // Overflow on imem, then clear rewinds and clears the error
      do_clear();
      for (int i = 0; i < 5; i++) push(1'b0, WW'($urandom));
      end_burst();
      chk("ovf_err", 32'(load_err), 32'd1);
      run(2, 0, 0, 0);
      do_clear();
      push(1'b0, 16'hBEEF);
      // Last load word together with start
      run(5, 0, 1, 0);

      // Randomized sessions
      for (int it = 0; it < 8; it++) begin
         if (!m_idle && $urandom_range(0, 1) == 1) do_clear();
         if (m_idle) begin
            for (int k = 0; k < int'($urandom_range(0, 6)); k++) push(1'($urandom), WW'($urandom));
            if ($urandom_range(0, 1) == 1) end_burst();
            run(int'($urandom_range(0, TO + 3)), 0, 1'($urandom), 1'($urandom));
         end else begin
            run(int'($urandom_range(0, TO + 3)), 1'($urandom), 0, 1'($urandom));
         end
      end

      // Reset mid-run at cycle_count 5
      start = 1; step(); start = 0;
      guard = 0;
      while (!(busy && !cpu_rst && cycle_count == 32'd5) && guard < 100) begin guard++; step(); end
      chk("mid_reach", 32'(guard < 100), 32'd1);
      #2 reset = 1;
      #1 chk_reset_vals("midrst");
      model_reset();
      @(posedge clk); #1; reset = 0;
      push(1'b0, 16'hCAFE);
      push(1'b1, 16'hF00D);
      end_burst();

      // Memory contents seen by the core versus the model
      for (int i = 0; i < int'(ID); i++) if (m_iv[i]) chk("imem_data", 32'(tb_imem[i]), 32'(m_imem[i]));
      for (int i = 0; i < int'(DD); i++) if (m_dv[i]) chk("dmem_data", 32'(tb_dmem[i]), 32'(m_dmem[i]));

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1, "bench time limit");
   end

endmodule

// File: doc/dsp_run_ctrl.md
# dsp_run_ctrl

Parametrised program-load and run controller for the `dsp` core. It streams instruction and data words into the core's instruction and data memories through a valid/ready port and holds the core in reset for a programmable pulse. It then runs the core until it signals halt or a cycle budget expires, and reports cycle count and a done/timeout status. This replaces fixed-delay, file-preload test sequencing with a reusable sequencer that sits between a host or bench and the `dsp` top level.

## Interface

Parameters:
- `WORD_W`, 16: width of instruction and data words.
- `IMEM_DEPTH`, 256: instruction memory depth in words; address width is clog2 of this.
- `DMEM_DEPTH`, 256: data memory depth in words; address width is clog2 of this.
- `RST_CYCLES`, 4: core reset pulse length in cycles, ≥1.
- `TIMEOUT`, 4096: maximum RUN cycles, ≥1, < 2^32.

Ports:
- `clk` in 1: single clock. Everything is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `load_valid` in 1: a load word is present.
- `load_ready` out 1: the controller accepts load words.
- `load_sel` in 1: selects the target memory. 0 = instruction memory, 1 = data memory.
- `load_data` in WORD_W: word to write.
- `start` in 1: pulse that begins a run.
- `clear` in 1: pulse that returns from DONE to IDLE and rewinds the load addresses.
- `imem_we` out 1, `imem_addr` out clog2(IMEM_DEPTH), `imem_wdata` out WORD_W: instruction memory write port.
- `dmem_we` out 1, `dmem_addr` out clog2(DMEM_DEPTH), `dmem_wdata` out WORD_W: data memory write port.
- `cpu_rst` out 1: reset to the `dsp` core.
- `cpu_halt` in 1: the core has finished.
- `busy` out 1: high in RSTP and RUN.
- `done` out 1: high in DONE.
- `timeout` out 1: the run ended on the cycle budget.
- `load_err` out 1: sticky. A word was dropped because its memory was full.
- `cycle_count` out 32: RUN cycles counted in the last run.

## Operation

States: IDLE, RSTP, RUN, DONE.

- **IDLE.** `load_ready`=1.
  - A handshake is `load_valid & load_ready`. It writes `load_data` to the memory chosen by `load_sel`, at that memory's address counter, then increments that counter.
  - The two counters are independent.
  - If the selected counter already equals its DEPTH, the word is dropped, no write occurs, and `load_err` is set.
  - `start`=1 moves to RSTP. The RSTP counter, `cycle_count`, and `timeout` are cleared.
- **RSTP.** `cpu_rst`=1 for exactly RST_CYCLES cycles, then the state moves to RUN.
- **RUN.** `cpu_rst`=0.
  - `cpu_halt`=1 sampled: move to DONE with `timeout`=0. `cycle_count` is not incremented on that cycle.
  - Otherwise, if `cycle_count`==TIMEOUT: move to DONE with `timeout`=1.
  - Otherwise, `cycle_count` increments by 1.
- **DONE.** `cpu_rst`=1. `cycle_count` and `timeout` hold their values.
  - `start` re-runs the program by moving to RSTP. The memories keep their contents and the load addresses are not rewound.
  - `clear` moves to IDLE, zeroes both load address counters, and clears `load_err`.
  - If `start` and `clear` are both high, `start` wins.

Decode rules:
- `cpu_rst`=1 in every state except RUN.
- `load_ready`=1 only in IDLE.
- `start` is ignored in RSTP and RUN. `clear` is ignored in IDLE, RSTP and RUN.
- A `load_valid` outside IDLE is not accepted and has no effect.

## Timing

- Reset values:
  - state IDLE, so `load_ready`=1 and `cpu_rst`=1.
  - `imem_we`=`dmem_we`=0; all addresses and wdata are 0.
  - `busy`=`done`=`timeout`=`load_err`=0; `cycle_count`=0.
- Reset asserted mid-run or mid-load aborts immediately to these values. Memory contents are not touched.
- Write ports are registered. A handshake at edge N drives `*_we`=1 with the address and data during cycle N+1. `*_we` is a one-cycle pulse per word. Back-to-back handshakes give back-to-back writes.
- A `start` sampled in IDLE together with a final `load_valid`: the word is written and the state enters RSTP. That last write still completes on the following cycle.
- State outputs (`cpu_rst`, `busy`, `done`, `load_ready`) decode directly from the state register. They change the cycle after the causing edge and have no extra latency.
- The `start` edge to the first `cpu_rst`=0 cycle is RST_CYCLES+1 edges.
- `cpu_halt` sampled at edge M gives `done`=1 from the cycle after M.
- A run that never halts yields `cycle_count`=TIMEOUT and `timeout`=1. It leaves RUN after TIMEOUT+1 RUN cycles.

## Test plan

- **Basic load and run.** Reset; load 3 imem words (0x1111, 0x2222, 0x3333), then 2 dmem words (0xA5A5, 0x5A5A).
  - Expect `imem_addr` 0,1,2 and `dmem_addr` 0,1 with the matching wdata, each `*_we` one cycle after its handshake.
  - Then `start`; expect `cpu_rst` high for RST_CYCLES=4 cycles then low.
  - Raise `cpu_halt` after 10 RUN cycles; expect `cycle_count`=10, `done`=1, `timeout`=0, `cpu_rst`=1.
- **Timeout.** With TIMEOUT=16, start and never halt; expect `cycle_count`=16, `timeout`=1, `done`=1.
- **Overflow.** With IMEM_DEPTH=4, push 5 imem words; expect 4 writes at addresses 0..3, no 5th `imem_we`, `load_err`=1. Then `clear` from DONE; expect `load_err`=0 and the next write at address 0.
- **Simultaneous events.**
  - `start` on the same cycle as the last `load_valid`: the word is written and RSTP is entered.
  - `cpu_halt` on the cycle `cycle_count` reaches TIMEOUT: `timeout`=0.
  - `start`+`clear` together in DONE: RSTP is entered.
- **Rerun and ignored inputs.**
  - `start` in DONE reruns with `cycle_count` restarting at 0.
  - `load_valid` and `start` pulsed during RUN cause no write and no restart.
- **Reset mid-run.** Assert `reset` during RUN at `cycle_count`=5; expect immediate IDLE, `cpu_rst`=1, `cycle_count`=0, both address counters at 0.
